// File: rtl/lts_fine_cfo_estimate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lts_fine_cfo_estimate_pkg
// Purpose : Shared types and constants for the LTS fine CFO estimator:
//           FSM state encoding, CORDIC arctangent table, phase constants.
// Revision: 1.0 - initial release
// ============================================================================
package lts_fine_cfo_estimate_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      CORR  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int CORDIC_ITERS  = 16;
   // Phase units: 65536 per full turn, so pi maps to 32768.
   localparam int PHASE_PI      = 32768;
   localparam int PHASE_HALF_PI = PHASE_PI / 2;

   // atan(2^-i) expressed in 16-bit phase units, rounded to nearest.
   function automatic logic [15:0] cordic_atan(input logic [3:0] idx);
      logic [15:0] val;
      case (idx)
         4'd0:    val = 16'd8192;
         4'd1:    val = 16'd4836;
         4'd2:    val = 16'd2555;
         4'd3:    val = 16'd1297;
         4'd4:    val = 16'd651;
         4'd5:    val = 16'd326;
         4'd6:    val = 16'd163;
         4'd7:    val = 16'd81;
         4'd8:    val = 16'd41;
         4'd9:    val = 16'd20;
         4'd10:   val = 16'd10;
         4'd11:   val = 16'd5;
         4'd12:   val = 16'd3;
         4'd13:   val = 16'd1;
         4'd14:   val = 16'd1;
         default: val = 16'd0;
      endcase
      return val;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lts_cfo_cordic_atan2.sv
`default_nettype none
// ============================================================================
// Module  : lts_cfo_cordic_atan2
// Purpose : Iterative vectoring CORDIC computing atan2(y, x) in 16-bit phase
//           units. One load cycle with left-half-plane pre-rotation, 16
//           micro-rotations at one per clock, one output cycle. Result
//           pulses 18 clocks after start. (0,0) yields phase 0.
// Revision: 1.0 - initial release
// ============================================================================
module lts_cfo_cordic_atan2
   import lts_fine_cfo_estimate_pkg::*;
#(
   parameter int IN_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic signed [IN_W-1:0] x_in,
   input  logic signed [IN_W-1:0] y_in,
   output logic                   busy,
   output logic                   phase_valid,
   output logic signed [15:0]     phase
);

   // Headroom for negating the most negative input and for CORDIC gain (~1.65).
   localparam int XW = IN_W + 3;

   localparam logic [15:0] Z_POS_HALF = 16'(PHASE_HALF_PI);
   localparam logic [15:0] Z_NEG_HALF = 16'(PHASE_PI + PHASE_HALF_PI);

   logic signed [XW-1:0] x_r;
   logic signed [XW-1:0] y_r;
   logic [15:0]          z_r;
   logic [4:0]           iter;
   logic                 active;
   logic                 zero_in;

   assign busy = active | start;

   // Load/pre-rotate on start, then iterate, then publish the angle.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r         <= '0;
         y_r         <= '0;
         z_r         <= '0;
         iter        <= '0;
         active      <= 1'b0;
         zero_in     <= 1'b0;
         phase_valid <= 1'b0;
         phase       <= '0;
      end else begin
         phase_valid <= 1'b0;
         if (start) begin
            active  <= 1'b1;
            iter    <= '0;
            zero_in <= (x_in == '0) && (y_in == '0);
            if (x_in < 0) begin
               // Rotate by -/+ 90 degrees into the right half-plane.
               if (y_in >= 0) begin
                  x_r <= XW'(y_in);
                  y_r <= -XW'(x_in);
                  z_r <= Z_POS_HALF;
               end else begin
                  x_r <= -XW'(y_in);
                  y_r <= XW'(x_in);
                  z_r <= Z_NEG_HALF;
               end
            end else begin
               x_r <= XW'(x_in);
               y_r <= XW'(y_in);
               z_r <= '0;
            end
         end else if (active) begin
            if (iter == 5'(CORDIC_ITERS)) begin
               active      <= 1'b0;
               phase_valid <= 1'b1;
               phase       <= zero_in ? 16'sd0 : signed'(z_r);
            end else begin
               iter <= iter + 5'd1;
               if (y_r >= 0) begin
                  x_r <= x_r + (y_r >>> iter);
                  y_r <= y_r - (x_r >>> iter);
                  z_r <= z_r + cordic_atan(iter[3:0]);
               end else begin
                  x_r <= x_r - (y_r >>> iter);
                  y_r <= y_r + (x_r >>> iter);
                  z_r <= z_r - cordic_atan(iter[3:0]);
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lts_fine_cfo_estimate.sv
`default_nettype none
// ============================================================================
// Module  : lts_fine_cfo_estimate
// Purpose : Buffers LTS1 and correlates it against LTS2 (sum of
//           conj(LTS1[n]) * LTS2[n]), outputs the averaged, saturated
//           complex correlation. With LTS_FINE_CFO_PHASE_EN defined, a
//           vectoring CORDIC also produces the correlation phase.
// Revision: 1.0 - initial release
// ============================================================================
module lts_fine_cfo_estimate
   import lts_fine_cfo_estimate_pkg::*;
#(
   parameter int SYM_LEN = 64,
   parameter int ACC_W   = 40,
   parameter int OUT_W   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    sample_in_valid,
   input  logic signed [15:0]      sample_in_i,
   input  logic signed [15:0]      sample_in_q,
   output logic                    cfo_corr_valid,
   output logic signed [OUT_W-1:0] cfo_corr_i,
   output logic signed [OUT_W-1:0] cfo_corr_q,
   output logic                    cfo_phase_valid,
   output logic signed [15:0]      cfo_phase,
   output logic                    busy
);

   localparam int CNT_W = $clog2(SYM_LEN);
   localparam int SHIFT = $clog2(SYM_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             fcnt, fcnt_next;
   logic             wr_en;
   logic             push;
   logic             result_load;

   logic [31:0]             buffer [SYM_LEN];
   logic [31:0]             rd_word;
   logic signed [15:0]      a_i, a_q;
   logic signed [32:0]      mul_re, mul_im;
   logic signed [32:0]      prod_re, prod_im;
   logic                    prod_vld;
   logic signed [ACC_W-1:0] acc_re, acc_im;
   logic signed [ACC_W-1:0] scaled_re, scaled_im;
   logic signed [OUT_W-1:0] sat_re, sat_im;
   logic                    fsm_busy;

   // State, sample counter and flush counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         fcnt  <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         fcnt  <= fcnt_next;
      end
   end

   // Next-state logic; dropping enable returns to IDLE and discards the sample.
   always_comb begin
      next_state  = state;
      cnt_next    = cnt;
      fcnt_next   = fcnt;
      wr_en       = 1'b0;
      push        = 1'b0;
      result_load = 1'b0;
      case (state)
         IDLE: begin
            if (sample_in_valid) begin
               wr_en      = 1'b1;
               cnt_next   = CNT_W'(1);
               next_state = FILL;
            end
         end
         FILL: begin
            if (sample_in_valid) begin
               wr_en    = 1'b1;
               cnt_next = cnt + 1'b1;   // wraps to 0 after the last LTS1 sample
               if (cnt == CNT_LAST) next_state = CORR;
            end
         end
         CORR: begin
            if (sample_in_valid) begin
               push     = 1'b1;
               cnt_next = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  next_state = FLUSH;
                  fcnt_next  = 1'b0;
               end
            end
         end
         FLUSH: begin
            fcnt_next = 1'b1;
            if (fcnt) begin
               result_load = 1'b1;
               next_state  = DONE;
            end
         end
         DONE: begin
            next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
      if (!enable) begin
         next_state  = IDLE;
         cnt_next    = '0;
         fcnt_next   = 1'b0;
         wr_en       = 1'b0;
         push        = 1'b0;
         result_load = 1'b0;
      end
   end

   // LTS1 buffer; contents need no reset since every entry is rewritten before use.
   always_ff @(posedge clk) begin
      if (wr_en) buffer[cnt] <= {sample_in_i, sample_in_q};
   end

   assign rd_word = buffer[cnt];
   assign a_i     = signed'(rd_word[31:16]);
   assign a_q     = signed'(rd_word[15:0]);

   // conj(a) * b
   assign mul_re = 33'(a_i) * 33'(sample_in_i) + 33'(a_q) * 33'(sample_in_q);
   assign mul_im = 33'(a_i) * 33'(sample_in_q) - 33'(a_q) * 33'(sample_in_i);

   // MAC stage 1: registered products, absorbing the buffer read.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         prod_vld <= 1'b0;
         prod_re  <= '0;
         prod_im  <= '0;
      end else begin
         prod_vld <= push;
         if (push) begin
            prod_re <= mul_re;
            prod_im <= mul_im;
         end
      end
   end

   // MAC stage 2: sign-extended accumulation, cleared while idle.
   always_ff @(posedge clk) begin
      if (rst || !enable || state == IDLE) begin
         acc_re <= '0;
         acc_im <= '0;
      end else if (prod_vld) begin
         acc_re <= acc_re + ACC_W'(prod_re);
         acc_im <= acc_im + ACC_W'(prod_im);
      end
   end

   // Average over the symbol length, then clamp to the output range.
   assign scaled_re = acc_re >>> SHIFT;
   assign scaled_im = acc_im >>> SHIFT;

   always_comb begin
      sat_re = scaled_re[OUT_W-1:0];
      sat_im = scaled_im[OUT_W-1:0];
      if (scaled_re > SAT_MAX) sat_re = SAT_MAX[OUT_W-1:0];
      else if (scaled_re < SAT_MIN) sat_re = SAT_MIN[OUT_W-1:0];
      if (scaled_im > SAT_MAX) sat_im = SAT_MAX[OUT_W-1:0];
      else if (scaled_im < SAT_MIN) sat_im = SAT_MIN[OUT_W-1:0];
   end

   // Result registers: loaded once per run, held until enable drops.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         cfo_corr_valid <= 1'b0;
         cfo_corr_i     <= '0;
         cfo_corr_q     <= '0;
      end else begin
         cfo_corr_valid <= result_load;
         if (result_load) begin
            cfo_corr_i <= sat_re;
            cfo_corr_q <= sat_im;
         end
      end
   end

   assign fsm_busy = (state == FILL) || (state == CORR) || (state == FLUSH);

`ifdef LTS_FINE_CFO_PHASE_EN
   logic cordic_busy;

   lts_cfo_cordic_atan2 #(
      .IN_W (OUT_W)
   ) u_cordic (
      .clk         (clk),
      .rst         (rst || !enable),
      .start       (cfo_corr_valid),
      .x_in        (cfo_corr_i),
      .y_in        (cfo_corr_q),
      .busy        (cordic_busy),
      .phase_valid (cfo_phase_valid),
      .phase       (cfo_phase)
   );

   assign busy = fsm_busy | cordic_busy;
`else
   assign cfo_phase_valid = 1'b0;
   assign cfo_phase       = '0;
   assign busy            = fsm_busy;
`endif

endmodule
`default_nettype wire
